// File: rtl/alu_standard_calculator_n_bit_pkg.sv
// Shared opcode constants and FSM state type for the signed N-bit calculator.
// Optional feature macro: ALU_MOD_OP_EN (enables the signed remainder opcode).
package alu_calc_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;

  // ST_LOAD is the cycle in which the first mul/div iteration runs,
  // right after operands were captured on the edge leaving ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_standard_calculator_n_bit_if.sv
// Operand/opcode/result bundle for the calculator, plus FSM state for observation.
// Handshake: there is no valid/ready pair; a rst pulse starts an operation and
// a, b, op must be held stable until result settles (at most N+1 edges later).
interface alu_standard_calculator_n_bit_if #(parameter int DATA_WIDTH = 4);
  import alu_calc_pkg::*;

  logic signed [DATA_WIDTH-1:0]   a;
  logic signed [DATA_WIDTH-1:0]   b;
  logic [2:0]                     op;
  logic signed [2*DATA_WIDTH-1:0] result;
  state_t                         state;

  modport master (output a, output b, output op, input result, input state);
  modport slave  (input a, input b, input op, output result, output state);
endinterface

// File: rtl/alu_standard_calculator_n_bit_shift_muldiv.sv
// Magnitude shift-add multiplier and restoring divider sharing one adder.
// Runs N iterations after start; done flags the cycle of the last iteration,
// and prod_quot/rem show the values that iteration is committing.
module alu_shift_muldiv #(parameter int N = 4) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           is_div,
  input  logic [N-1:0]   mag_a,
  input  logic [N-1:0]   mag_b,
  output logic           done,
  output logic [2*N-1:0] prod_quot,
  output logic [N-1:0]   rem
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // hi = partial product high half / partial remainder, lo = multiplier / quotient
  logic [N-1:0]  hi, lo, dv;
  logic [CW-1:0] cnt;
  logic          busy, div_q;

  logic [N:0]   t;
  logic [N+1:0] x, y, sum;
  logic [N:0]   hf;
  logic [N-1:0] nxt_hi, nxt_lo;

  // One adder: mul adds the multiplicand to hi, div subtracts the divisor from {hi, lo msb}
  always_comb begin
    t   = {hi, lo[N-1]};
    x   = div_q ? {1'b0, t} : {2'b00, hi};
    y   = div_q ? ~{2'b00, dv} : {2'b00, dv};
    sum = x + y + {{(N+1){1'b0}}, div_q};
    hf  = lo[0] ? sum[N:0] : {1'b0, hi};
    if (div_q) begin
      if (!sum[N+1]) begin
        nxt_hi = sum[N-1:0];
        nxt_lo = {lo[N-2:0], 1'b1};
      end else begin
        nxt_hi = t[N-1:0];
        nxt_lo = {lo[N-2:0], 1'b0};
      end
    end else begin
      nxt_hi = hf[N:1];
      nxt_lo = {hf[0], lo[N-1:1]};
    end
  end

  assign done      = busy && (cnt == LAST);
  assign prod_quot = div_q ? {{N{1'b0}}, nxt_lo} : {nxt_hi, nxt_lo};
  assign rem       = nxt_hi;

  // Load operands on start, then commit one iteration per edge while busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      div_q <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      dv    <= '0;
      cnt   <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      div_q <= is_div;
      hi    <= '0;
      lo    <= mag_a;
      dv    <= mag_b;
      cnt   <= '0;
    end else if (busy) begin
      hi  <= nxt_hi;
      lo  <= nxt_lo;
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_standard_calculator_n_bit.sv
// Signed N-bit calculator: add/sub in one edge, mul/div over N iterations.
// Each rst pulse restarts an operation; result holds until the next rst.
// Define ALU_MOD_OP_EN to add op 100 = signed remainder (sign follows a).
module alu_standard_calculator_n_bit
  import alu_calc_pkg::*;
#(parameter int DATA_WIDTH = 4) (
  input logic                           clk,
  input logic                           rst,
  alu_standard_calculator_n_bit_if.slave bus
);
  localparam int N = DATA_WIDTH;
  localparam int W = 2 * DATA_WIDTH;
  localparam logic [N-1:0] ONE_N = N'(1);
  localparam logic [W-1:0] ONE_W = W'(1);

  state_t       state_q;
  logic [W-1:0] result_q;
  logic         neg_q;
  logic [N-1:0] mag_a, mag_b;
  logic [W-1:0] sext_a, sext_b, signed_pq;
  logic         b_nz, start, is_div;
  logic         md_done;
  logic [W-1:0] md_pq;
  logic [N-1:0] md_rem;
`ifdef ALU_MOD_OP_EN
  logic         use_rem_q;
  logic [W-1:0] rem_ext, mod_res;
`endif

  assign mag_a  = bus.a[N-1] ? (~bus.a + ONE_N) : bus.a;
  assign mag_b  = bus.b[N-1] ? (~bus.b + ONE_N) : bus.b;
  assign sext_a = {{N{bus.a[N-1]}}, bus.a};
  assign sext_b = {{N{bus.b[N-1]}}, bus.b};
  assign b_nz   = (bus.b != '0);
  assign is_div = (bus.op != OP_MUL);
  // Product or zero-extended quotient magnitude, sign-corrected
  assign signed_pq = neg_q ? (~md_pq + ONE_W) : md_pq;
`ifdef ALU_MOD_OP_EN
  assign rem_ext = {{N{1'b0}}, md_rem};
  assign mod_res = neg_q ? (~rem_ext + ONE_W) : rem_ext;
`endif

  // Kick the iterative unit on the capture edge for ops that need it
  always_comb begin
    start = 1'b0;
    if (state_q == ST_IDLE) begin
      case (bus.op)
        OP_MUL:  start = 1'b1;
        OP_DIV:  start = b_nz;
`ifdef ALU_MOD_OP_EN
        OP_MOD:  start = b_nz;
`endif
        default: start = 1'b0;
      endcase
    end
  end

  alu_shift_muldiv #(.N(N)) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_div    (is_div),
    .mag_a     (mag_a),
    .mag_b     (mag_b),
    .done      (md_done),
    .prod_quot (md_pq),
    .rem       (md_rem)
  );

  // Control FSM with the result register; only rst leaves DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      neg_q    <= 1'b0;
`ifdef ALU_MOD_OP_EN
      use_rem_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          neg_q <= bus.a[N-1] ^ bus.b[N-1];
          case (bus.op)
            OP_ADD: begin
              result_q <= sext_a + sext_b;
              state_q  <= ST_DONE;
            end
            OP_SUB: begin
              result_q <= sext_a - sext_b;
              state_q  <= ST_DONE;
            end
            OP_MUL: state_q <= ST_LOAD;
            OP_DIV: begin
              if (b_nz) begin
                state_q <= ST_LOAD;
              end else begin
                result_q <= '1;
                state_q  <= ST_DONE;
              end
            end
`ifdef ALU_MOD_OP_EN
            OP_MOD: begin
              neg_q     <= bus.a[N-1];
              use_rem_q <= 1'b1;
              if (b_nz) begin
                state_q <= ST_LOAD;
              end else begin
                result_q <= sext_a;
                state_q  <= ST_DONE;
              end
            end
`endif
            default: begin
              result_q <= '0;
              state_q  <= ST_DONE;
            end
          endcase
        end
        ST_LOAD, ST_RUN: begin
          if (md_done) begin
`ifdef ALU_MOD_OP_EN
            result_q <= use_rem_q ? mod_res : signed_pq;
`else
            result_q <= signed_pq;
`endif
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_DONE;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.state  = state_q;
endmodule

// File: tb/tb_alu_standard_calculator_n_bit.sv
// Bench for the signed N-bit calculator (N=4): directed cases, reset abort,
// exhaustive add/sub/mul/div against an integer model, reserved opcodes.
module tb_alu_standard_calculator_n_bit;
  import alu_calc_pkg::*;

  localparam int N = 4;
  localparam int W = 2 * N;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [W-1:0] exp_q[$];

  alu_standard_calculator_n_bit_if #(.DATA_WIDTH(N)) bus ();

  alu_standard_calculator_n_bit #(.DATA_WIDTH(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] model(input logic [N-1:0] ta, input logic [N-1:0] tb_,
                                         input logic [2:0] top);
    int sa, sb, r;
    sa = $signed(ta);
    sb = $signed(tb_);
    case (top)
      3'd0: r = sa + sb;
      3'd1: r = sa - sb;
      3'd2: r = sa * sb;
      3'd3: r = (sb == 0) ? -1 : sa / sb;
`ifdef ALU_MOD_OP_EN
      3'd4: r = (sb == 0) ? sa : sa % sb;
`endif
      default: r = 0;
    endcase
    return W'(r);
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s: got=%h expected=%h", tag, got, expv);
    end
  endtask

  // driver: pulse rst with operands applied, then check early/final/hold values
  task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_, input logic [2:0] top,
                        input logic [W-1:0] expv, input string tag);
    logic [W-1:0] early, fin;
    @(negedge clk);
    bus.a  = ta;
    bus.b  = tb_;
    bus.op = top;
    rst    = 1'b1;
    exp_q.push_back(expv);
    #1;
    check({tag, " reset"}, bus.result, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (N) @(negedge clk);
    // mul/div (nonzero divisor) results appear only on the last iteration edge
    early = ((top == 3'd2) || ((top == 3'd3 || top == 3'd4) && tb_ != '0)) ? '0 : expv;
    check({tag, " before_last_edge"}, bus.result, early);
    @(negedge clk);
    fin = exp_q.pop_front();
    check({tag, " final"}, bus.result, fin);
    for (int k = 0; k < 3; k++) begin
      bus.a  = N'($urandom_range(0, 15));
      bus.b  = N'($urandom_range(0, 15));
      bus.op = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
    check({tag, " hold"}, bus.result, fin);
  endtask

  initial begin
    logic [2:0] rop;
    logic [N-1:0] ra, rb;
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    bus.a  = '0;
    bus.b  = '0;
    bus.op = 3'd0;
    repeat (2) @(negedge clk);
    check("initial_reset", bus.result, '0);
    check("initial_state", W'(bus.state), W'(ST_IDLE));

    run_op(4'd3, 4'hE, 3'd0, 8'h01, "add_3_m2");
    run_op(4'd3, 4'hE, 3'd1, 8'h05, "sub_3_m2");
    run_op(4'h8, 4'h8, 3'd2, 8'h40, "mul_m8_m8");
    run_op(4'd7, 4'h8, 3'd2, 8'hC8, "mul_7_m8");
    run_op(4'h9, 4'd2, 3'd3, 8'hFD, "div_m7_2");
    run_op(4'h8, 4'hF, 3'd3, 8'h08, "div_m8_m1");
    run_op(4'd5, 4'd0, 3'd3, 8'hFF, "div_5_0");
    run_op(4'd7, 4'd3, 3'd7, 8'h00, "op111");
`ifdef ALU_MOD_OP_EN
    run_op(4'h9, 4'd2, 3'd4, 8'hFF, "mod_m7_2");
`else
    run_op(4'h9, 4'd2, 3'd4, 8'h00, "op100_reserved");
`endif

    // reset mid-multiply aborts, the restarted op completes normally
    @(negedge clk);
    bus.a  = 4'd7;
    bus.b  = 4'd3;
    bus.op = 3'd2;
    rst    = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_result", bus.result, '0);
    check("abort_state", W'(bus.state), W'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    repeat (N + 1) @(negedge clk);
    check("abort_restart", bus.result, 8'h15);
    check("abort_done_state", W'(bus.state), W'(ST_DONE));

    // exhaustive sweep against the integer model
    for (int o = 0; o < 4; o++)
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++)
          run_op(N'(i), N'(j), 3'(o), model(N'(i), N'(j), 3'(o)), $sformatf("sweep_op%0d_a%0d_b%0d", o, i, j));

    // random mix including reserved opcodes
    for (int k = 0; k < 40; k++) begin
      ra  = N'($urandom_range(0, 15));
      rb  = N'($urandom_range(0, 15));
      rop = 3'($urandom_range(0, 7));
      run_op(ra, rb, rop, model(ra, rb, rop), $sformatf("rand_op%0d_a%0d_b%0d", rop, ra, rb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
